spi_slave_interface: RTL and testbench

- SPI responder (slave) at the far end of the thermostat SPI link.
- Receives one 20-bit frame on MOSI per chip-select window and returns a pre-loaded 20-bit word on MISO in the same window.
- Sits beside the sensor and actuator logic of the house-side node, fully in the `clk` domain.
- SPI pins are asynchronous inputs, oversampled through synchronisers.

---
 rtl/spi_slave_interface_pkg.sv | 21 ++
 rtl/spi_slave_interface_sync_edge.sv | 43 ++++
 rtl/spi_slave_interface.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_interface.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_interface_pkg
// Purpose : Constants and state encoding shared by both ends of the
//           thermostat SPI link.
// Rev     : 1.0  initial release
// ============================================================================
package spi_slave_interface_pkg;

  localparam int SPI_DATA_W      = 20;
  localparam int SPI_CNT_W       = 5;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_interface_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync_edge
// Purpose : Multi-stage synchroniser for an asynchronous pin, followed by a
//           history register that yields single-cycle rise/fall pulses.
// Rev     : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;
  logic              w_sync;

  assign w_sync = r_chain[STAGES-1];

  // Synchroniser chain plus one history flop; everything clears to 0 so a
  // pin that is already low after reset never produces a spurious fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
      r_prev <= w_sync;
    end
  end

  assign rise = w_sync & ~r_prev;
  assign fall = ~w_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_interface.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_interface
// Purpose : SPI mode-0 responder. Receives one DATA_W-bit frame per chip
//           select window on MOSI and returns a pre-loaded word on MISO.
// Rev     : 1.0  initial release
// ============================================================================
module spi_slave_interface
  import spi_slave_interface_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter int CNT_W       = SPI_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(DATA_W + 1);

  logic w_sclk_rise, w_sclk_fall;
  logic w_cs_rise, w_cs_fall;
  logic w_mosi_sync;

  logic [SYNC_STAGES-1:0] r_mosi_chain;

  spi_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
  logic              r_miso, w_miso_nxt;
  logic [DATA_W-1:0] r_tx_shadow;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_cs_pend;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (w_cs_rise),
    .fall (w_cs_fall)
  );

  // MOSI goes through the same depth as sclk so the sampled bit lines up
  // with the detected rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mosi_chain <= '0;
    end else begin
      r_mosi_chain[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_mosi_chain[i] <= r_mosi_chain[i-1];
      end
    end
  end

  assign w_mosi_sync = r_mosi_chain[SYNC_STAGES-1];

  // State and shift-path registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_miso     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_miso     <= w_miso_nxt;
    end
  end

  // Next-state and shift-path logic; a cs_n event takes priority over any
  // sclk edge detected in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_miso_nxt     = r_miso;
    case (r_state)
      IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_cs_fall || r_cs_pend) begin
          w_tx_shift_nxt = r_tx_shadow;
          w_miso_nxt     = r_tx_shadow[DATA_W-1];
          w_cnt_nxt      = '0;
          w_state_nxt    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = DONE;
        end else if (w_sclk_rise) begin
          w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], w_mosi_sync};
          if (r_cnt != c_cnt_sat) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (w_sclk_fall && (r_cnt < c_cnt_full)) begin
          w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
          w_miso_nxt     = r_tx_shift[DATA_W-2];
        end
      end
      DONE: begin
        w_miso_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_miso_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Frame completion results, shadow word and re-select tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_shadow <= '0;
      r_cs_pend   <= 1'b0;
    end else begin
      r_rx_valid  <= (r_state == DONE) && (r_cnt == c_cnt_full);
      r_frame_err <= (r_state == DONE) && (r_cnt != c_cnt_full);
      if ((r_state == DONE) && (r_cnt == c_cnt_full)) begin
        r_rx_data <= r_rx_shift;
      end
      if (tx_load) begin
        r_tx_shadow <= tx_data;
      end
      // A new select arriving during the DONE cycle is replayed in IDLE.
      r_cs_pend <= (r_state == DONE) && w_cs_fall;
    end
  end

  assign miso      = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_interface.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_interface
// Purpose : Directed self-checking bench for spi_slave_interface, acting as
//           an SPI mode-0 master at clk/10.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_slave_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [19:0] tx_data;
  logic        tx_load;
  logic [19:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;

  logic [19:0] cap;
  logic        busy_mid;
  int          v0, e0;

  always #5 clk = ~clk;

  spi_slave_interface dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Count cycles during which each pulse output is high.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [19:0] w);
    @(negedge clk);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // One chip-select window with nedges sclk pulses, MSB first.
  task automatic send_frame(input logic [19:0] word, input int nedges,
                            input bit release_cs, input bit mid_load,
                            input logic [19:0] load_val,
                            output logic [19:0] cap_o, output logic busy_o);
    logic [19:0] c;
    c = '0;
    sclk = 1'b0;
    mosi = word[19];
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    busy_o = busy;
    for (int i = 0; i < nedges; i++) begin
      mosi = (i < 20) ? word[19-i] : 1'b0;
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      c = {c[18:0], miso};
      if (mid_load && i == 10) begin
        tx_data = load_val;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    if (release_cs) begin
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
    end
    cap_o = c;
  endtask

  initial begin
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_rx_data", {12'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // Basic frame
    load_word(20'd5);
    v0 = n_valid; e0 = n_err;
    send_frame(20'd6, 20, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t1_busy_mid", {31'd0, busy_mid}, 32'd1);
    chk("t1_rx_data", {12'd0, rx_data}, 32'd6);
    chk("t1_valid_cnt", n_valid - v0, 32'd1);
    chk("t1_err_cnt", n_err - e0, 32'd0);
    chk("t1_miso_word", {12'd0, cap}, 32'd5);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_miso_idle", {31'd0, miso}, 32'd0);

    // Back-to-back frames, shadow repeats
    v0 = n_valid;
    send_frame(20'd10, 20, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t2a_rx_data", {12'd0, rx_data}, 32'd10);
    chk("t2a_miso_word", {12'd0, cap}, 32'd5);
    send_frame(20'd35, 20, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t2b_rx_data", {12'd0, rx_data}, 32'd35);
    chk("t2b_miso_word", {12'd0, cap}, 32'd5);
    chk("t2_valid_cnt", n_valid - v0, 32'd2);

    // Reload during a frame applies to the next one
    send_frame(20'd40, 20, 1'b1, 1'b1, 20'd50, cap, busy_mid);
    chk("t3_miso_word", {12'd0, cap}, 32'd5);
    chk("t3_rx_data", {12'd0, rx_data}, 32'd40);
    send_frame(20'd7, 20, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t3_next_miso", {12'd0, cap}, 32'd50);
    chk("t3_next_rx", {12'd0, rx_data}, 32'd7);

    // Short frame
    v0 = n_valid; e0 = n_err;
    send_frame(20'hFD555, 12, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t4_err_cnt", n_err - e0, 32'd1);
    chk("t4_valid_cnt", n_valid - v0, 32'd0);
    chk("t4_rx_kept", {12'd0, rx_data}, 32'd7);

    // Overrun, then recovery
    v0 = n_valid; e0 = n_err;
    send_frame(20'h12345, 22, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t5_err_cnt", n_err - e0, 32'd1);
    chk("t5_valid_cnt", n_valid - v0, 32'd0);
    chk("t5_rx_kept", {12'd0, rx_data}, 32'd7);
    e0 = n_err;
    send_frame(20'd100, 20, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t5_next_rx", {12'd0, rx_data}, 32'd100);
    chk("t5_next_miso", {12'd0, cap}, 32'd50);
    chk("t5_next_err", n_err - e0, 32'd0);

    // Reset in the middle of a frame
    v0 = n_valid; e0 = n_err;
    send_frame(20'd333, 8, 1'b0, 1'b0, 20'd0, cap, busy_mid);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_rx_data", {12'd0, rx_data}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_miso", {31'd0, miso}, 32'd0);
    chk("t6_rst_pulses", {30'd0, rx_valid, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_wait_fresh_fall", {31'd0, busy}, 32'd0);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(20'd444, 20, 1'b1, 1'b0, 20'd0, cap, busy_mid);
    chk("t6_rx_data", {12'd0, rx_data}, 32'd444);
    chk("t6_miso_word", {12'd0, cap}, 32'd0);
    chk("t6_err_cnt", n_err - e0, 32'd0);
    chk("t6_valid_cnt", n_valid - v0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
